seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 35 +++
 rtl/seq_muldiv.sv | 71 +++++++
 rtl/seq_alu.sv | 193 +++++++++++++++++++
 tb/tb_seq_alu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings, flag bit positions and FSM state type for seq_alu.
package seq_alu_pkg;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_DIV  = 8'h04;
    localparam logic [7:0] OP_MOD  = 8'h05;
    localparam logic [7:0] OP_AND  = 8'h06;
    localparam logic [7:0] OP_OR   = 8'h07;
    localparam logic [7:0] OP_XOR  = 8'h08;
    localparam logic [7:0] OP_NOT  = 8'h09;
    localparam logic [7:0] OP_NOR  = 8'h0A;
    localparam logic [7:0] OP_NAND = 8'h0B;
    localparam logic [7:0] OP_XNOR = 8'h0C;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_CARRY   = 1;
    localparam int FLAG_SIGN    = 2;
    localparam int FLAG_PARITY  = 3;
    localparam int FLAG_DIVZ    = 4;
    localparam int FLAG_INVALID = 5;
    localparam int FLAG_OVF     = 6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Multi-cycle ops; divide by zero short-circuits to the single-cycle path.
    function automatic logic is_iterative(input logic [7:0] op, input logic divisor_zero);
        return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && !divisor_zero);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock.
// Terminal count (cnt == 0 while busy) marks the completion cycle.
module seq_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_mul,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             fin,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic             busy;
    logic             mul_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    assign fin = busy && (cnt == '0);

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
        rem_sh   = {hi, lo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, m_q};
    end

    // hi/lo: product halves for MUL, remainder/quotient for DIV.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            busy  <= 1'b0;
            mul_q <= 1'b0;
            m_q   <= '0;
            lo    <= '0;
            hi    <= '0;
        end else if (load) begin
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            mul_q <= is_mul;
            m_q   <= is_mul ? op_a : op_b;
            lo    <= is_mul ? op_b : op_a;
            hi    <= '0;
        end else if (busy) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
                if (mul_q) begin
                    {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
                end else if (rem_sh >= {1'b0, m_q}) begin
                    hi <= rem_diff[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= rem_sh[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arith/logic ops, iterative MUL/DIV/MOD via seq_muldiv.
//   state  | meaning
//   S_IDLE | ready; single-cycle ops complete one edge after acceptance
//   S_RUN  | seq_muldiv iterating; start ignored until terminal count
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [7:0]       flags
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             load_md;
    logic             pend;
    logic [7:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             md_fin;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic             is_mul_in;

    logic [WIDTH:0]   add_w;
    logic [WIDTH-1:0] sub_w;
    logic [WIDTH-1:0] s_res;
    logic [WIDTH-1:0] s_hi;
    logic             s_carry;
    logic             s_ovf;
    logic             s_dz;
    logic             s_inv;

    logic [WIDTH-1:0] o_res;
    logic [WIDTH-1:0] o_hi;
    logic             o_carry;
    logic             o_ovf;
    logic             o_dz;
    logic             o_inv;
    logic [7:0]       flags_nxt;

    assign ready     = (state == S_IDLE);
    assign is_mul_in = (opcode == OP_MUL);

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .load   (load_md),
        .is_mul (is_mul_in),
        .op_a   (operand1),
        .op_b   (operand2),
        .fin    (md_fin),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_md   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (is_iterative(opcode, operand2 == '0)) begin
                        load_md   = 1'b1;
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (md_fin) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // DIV/MOD only land here when the divisor is zero.
    always_comb begin
        s_res   = '0;
        s_hi    = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        s_dz    = 1'b0;
        s_inv   = 1'b0;
        add_w   = {1'b0, a_q} + {1'b0, b_q};
        sub_w   = a_q - b_q;
        case (op_q)
            OP_ADD: begin
                s_res   = add_w[WIDTH-1:0];
                s_carry = add_w[WIDTH];
                s_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                s_res   = sub_w;
                s_carry = (a_q < b_q);
                s_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_MUL:  s_res = '0;
            OP_DIV: begin
                s_res = '1;
                s_hi  = a_q;
                s_dz  = 1'b1;
            end
            OP_MOD: begin
                s_res = a_q;
                s_dz  = 1'b1;
            end
            OP_AND:  s_res = a_q & b_q;
            OP_OR:   s_res = a_q | b_q;
            OP_XOR:  s_res = a_q ^ b_q;
            OP_NOT:  s_res = ~a_q;
            OP_NOR:  s_res = ~(a_q | b_q);
            OP_NAND: s_res = ~(a_q & b_q);
            OP_XNOR: s_res = ~(a_q ^ b_q);
            default: s_inv = 1'b1;
        endcase
    end

    always_comb begin
        o_res   = s_res;
        o_hi    = s_hi;
        o_carry = s_carry;
        o_ovf   = s_ovf;
        o_dz    = s_dz;
        o_inv   = s_inv;
        if (!pend) begin
            o_res   = (op_q == OP_MOD) ? md_hi : md_lo;
            o_hi    = (op_q == OP_MOD) ? '0 : md_hi;
            o_carry = (op_q == OP_MUL) && (md_hi != '0);
            o_ovf   = 1'b0;
            o_dz    = 1'b0;
            o_inv   = 1'b0;
        end
        flags_nxt               = '0;
        flags_nxt[FLAG_ZERO]    = (o_res == '0);
        flags_nxt[FLAG_CARRY]   = o_carry;
        flags_nxt[FLAG_SIGN]    = o_res[WIDTH-1];
        flags_nxt[FLAG_PARITY]  = ~^o_res;
        flags_nxt[FLAG_DIVZ]    = o_dz;
        flags_nxt[FLAG_INVALID] = o_inv;
        flags_nxt[FLAG_OVF]     = o_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            pend      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else begin
            if (accept) begin
                op_q <= opcode;
                a_q  <= operand1;
                b_q  <= operand2;
            end
            pend <= accept && !load_md;
            done <= pend || md_fin;
            if (pend || md_fin) begin
                result    <= o_res;
                result_hi <= o_hi;
                flags     <= flags_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus randomized check of seq_alu (WIDTH=8) against a scoreboard of expected results.
module tb_seq_alu;

    typedef struct {
        logic [7:0] r;
        logic [7:0] h;
        logic [7:0] f;
        int         lat;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] opcode;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic       ready;
    logic       done;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic [7:0] flags;

    int   tests;
    int   fails;
    exp_t sb[$];

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .operand1  (operand1),
        .operand2  (operand2),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic [7:0] h, input logic [7:0] f, input int lat);
        exp_t e;
        e.r = r; e.h = h; e.f = f; e.lat = lat;
        return e;
    endfunction

    function automatic exp_t model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [8:0]  s;
        logic [15:0] p;
        logic        c, ov, dz, inv;
        e.r = 8'h00; e.h = 8'h00; e.lat = 1;
        c = 1'b0; ov = 1'b0; dz = 1'b0; inv = 1'b0;
        case (op)
            8'h01: begin
                s = {1'b0, a} + {1'b0, b};
                e.r = s[7:0]; c = s[8];
                ov = (a[7] == b[7]) && (e.r[7] != a[7]);
            end
            8'h02: begin
                e.r = a - b; c = (a < b);
                ov = (a[7] != b[7]) && (e.r[7] != a[7]);
            end
            8'h03: begin
                p = 16'(a) * 16'(b);
                e.r = p[7:0]; e.h = p[15:8]; c = (e.h != 8'h00); e.lat = 9;
            end
            8'h04: begin
                if (b == 8'h00) begin e.r = 8'hFF; e.h = a; dz = 1'b1; end
                else begin e.r = a / b; e.h = a % b; e.lat = 9; end
            end
            8'h05: begin
                if (b == 8'h00) begin e.r = a; dz = 1'b1; end
                else begin e.r = a % b; e.lat = 9; end
            end
            8'h06: e.r = a & b;
            8'h07: e.r = a | b;
            8'h08: e.r = a ^ b;
            8'h09: e.r = ~a;
            8'h0A: e.r = ~(a | b);
            8'h0B: e.r = ~(a & b);
            8'h0C: e.r = ~(a ^ b);
            default: inv = 1'b1;
        endcase
        e.f = {1'b0, ov, inv, dz, ~^e.r, e.r[7], c, (e.r == 8'h00)};
        return e;
    endfunction

    // Waits for done (bounded), checks latency and pops the expected result.
    task automatic await_op(input string tag);
        int   cyc;
        int   lat;
        exp_t e;
        cyc = 0;
        lat = (sb.size() > 0) ? sb[0].lat : 1;
        while (done !== 1'b1 && cyc < 40) begin
            check({tag, "/ready_busy"}, 32'(ready), 32'(lat == 1));
            tick();
            cyc++;
        end
        check({tag, "/latency"}, 32'(cyc), 32'(lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "/result"}, 32'(result), 32'(e.r));
            check({tag, "/result_hi"}, 32'(result_hi), 32'(e.h));
            check({tag, "/flags"}, 32'(flags), 32'(e.f));
        end else begin
            tests++;
            fails++;
            $error("FAIL %s no expectation queued, result=0x%0h", tag, result);
        end
        check({tag, "/ready_at_done"}, 32'(ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b, input exp_t e);
        check({tag, "/ready_pre"}, 32'(ready), 32'd1);
        start = 1'b1; opcode = op; operand1 = a; operand2 = b;
        sb.push_back(e);
        tick();
        start = 1'b0;
        opcode   = 8'($urandom);
        operand1 = 8'($urandom);
        operand2 = 8'($urandom);
        await_op(tag);
        tick();
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [7:0] op, a, b;
        logic       seen_done;
        tests = 0; fails = 0;
        reset = 1'b1; start = 1'b0; opcode = 8'h00; operand1 = 8'h00; operand2 = 8'h00;
        tick();
        tick();
        check("rst/ready", 32'(ready), 32'd1);
        check("rst/done", 32'(done), 32'd0);
        check("rst/result", 32'(result), 32'd0);
        check("rst/result_hi", 32'(result_hi), 32'd0);
        check("rst/flags", 32'(flags), 32'd0);
        reset = 1'b0;
        tick();

        run_op("add_carry", 8'h01, 8'd200, 8'd100, mk(8'h2C, 8'h00, 8'h02, 1));
        run_op("add_ovf",   8'h01, 8'd127, 8'd1,   mk(8'h80, 8'h00, 8'h44, 1));
        run_op("sub_borrow", 8'h02, 8'd5, 8'd10,   mk(8'hFB, 8'h00, 8'h06, 1));
        run_op("sub_zero",  8'h02, 8'd9, 8'd9,     mk(8'h00, 8'h00, 8'h09, 1));
        run_op("mul",       8'h03, 8'd25, 8'd20,   mk(8'hF4, 8'h01, 8'h06, 9));
        run_op("div",       8'h04, 8'd200, 8'd7,   mk(8'h1C, 8'h04, 8'h00, 9));
        run_op("div_zero",  8'h04, 8'd200, 8'd0,   mk(8'hFF, 8'hC8, 8'h1C, 1));
        run_op("mod",       8'h05, 8'd200, 8'd7,   mk(8'h04, 8'h00, 8'h00, 9));
        run_op("mod_zero",  8'h05, 8'h35, 8'd0,    mk(8'h35, 8'h00, 8'h18, 1));
        run_op("xor",       8'h08, 8'hF0, 8'h0F,   mk(8'hFF, 8'h00, 8'h0C, 1));
        run_op("nand",      8'h0B, 8'hFF, 8'hFF,   mk(8'h00, 8'h00, 8'h09, 1));

        // Reset four edges into a multiply: aborted, no done, outputs cleared.
        start = 1'b1; opcode = 8'h03; operand1 = 8'd25; operand2 = 8'd20;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort/done", 32'(done), 32'd0);
        check("abort/ready", 32'(ready), 32'd1);
        check("abort/result", 32'(result), 32'd0);
        check("abort/result_hi", 32'(result_hi), 32'd0);
        check("abort/flags", 32'(flags), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("abort/no_done", 32'(seen_done), 32'd0);
        run_op("add_after_abort", 8'h01, 8'd1, 8'd1, mk(8'h02, 8'h00, 8'h00, 1));

        // Start held through a multiply: ignored while running, taken right after done.
        sb.push_back(mk(8'h0F, 8'h00, 8'h08, 9));
        start = 1'b1; opcode = 8'h03; operand1 = 8'd3; operand2 = 8'd5;
        tick();
        opcode = 8'hFF; operand1 = 8'h55; operand2 = 8'h00;
        await_op("mul_held");
        sb.push_back(mk(8'h00, 8'h00, 8'h29, 1));
        tick();
        start = 1'b0;
        await_op("invalid_b2b");
        tick();
        check("invalid_b2b/done_pulse", 32'(done), 32'd0);

        for (int i = 0; i < 14; i++) begin
            op = 8'($urandom_range(0, 14));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            run_op($sformatf("rand%0d_op%0h", i, op), op, a, b, model(op, a, b));
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
